// File: rtl/regport_arbiter.sv
// Two-requester round-robin arbiter for one register-file read-address port.
// The grant is registered; the address mux follows the grant combinationally.
module regport_arbiter #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [ADDR_W-1:0] port_addr,
  output logic              port_valid
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;      // 1 = requester 1 owned the port most recently
  logic [CNT_W-1:0] r_hold;
  logic             w_hold_sat;
  logic             w_enter;

  assign w_hold_sat = (r_hold == HOLD_LAST);
  assign w_enter    = (w_state_nxt != r_state) && (w_state_nxt != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (req0 && !req1)      w_state_nxt = G0;
        else if (req1 && !req0) w_state_nxt = G1;
        else if (req0 && req1)  w_state_nxt = r_last ? G0 : G1;
      end
      G0: begin
        if (!req0)                     w_state_nxt = req1 ? G1 : IDLE;
        else if (req1 && w_hold_sat)   w_state_nxt = G1;
      end
      G1: begin
        if (!req1)                     w_state_nxt = req0 ? G0 : IDLE;
        else if (req0 && w_hold_sat)   w_state_nxt = G0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter) begin
        r_hold <= '0;
        r_last <= (w_state_nxt == G1);
      end else if (w_state_nxt == IDLE) begin
        r_hold <= '0;
      end else if (!w_hold_sat) begin
        r_hold <= r_hold + CNT_W'(1);
      end
    end
  end

  assign gnt0       = (r_state == G0);
  assign gnt1       = (r_state == G1);
  assign sel        = gnt1;
  assign port_valid = gnt0 | gnt1;
  assign port_addr  = sel ? addr1 : addr0;

endmodule

// File: tb/tb_regport_arbiter.sv
// Table-driven bench for regport_arbiter with a scoreboard queue of expected outputs;
// a second instance with MAX_HOLD=1 covers the every-cycle alternation case.
module tb_regport_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] addr0, addr1;
  logic       gnt0, gnt1, sel, port_valid;
  logic [3:0] port_addr;
  logic       h_gnt0, h_gnt1, h_sel, h_port_valid;
  logic [3:0] h_port_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regport_arbiter #(.ADDR_W(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .port_addr(port_addr), .port_valid(port_valid)
  );

  regport_arbiter #(.ADDR_W(4), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(h_gnt0), .gnt1(h_gnt1), .sel(h_sel), .port_addr(h_port_addr), .port_valid(h_port_valid)
  );

  a_excl: assert property (@(posedge clk) !(gnt0 && gnt1) && !(h_gnt0 && h_gnt1));
  a_valid: assert property (@(posedge clk) (port_valid == (gnt0 | gnt1)));

  typedef struct {
    logic       rst, r0, r1;
    logic [3:0] a0, a1;
    logic       g0, g1;
    logic       chk;
  } vec_t;

  typedef struct {
    int         idx;
    logic       which;   // 0 = main instance, 1 = MAX_HOLD=1 instance
    logic       g0, g1, sel, valid;
    logic [3:0] addr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic r, input logic q0, input logic q1,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic g0, input logic g1, input logic chk);
    vec_t v;
    v.rst = r; v.r0 = q0; v.r1 = q1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.chk = chk;
    vecs.push_back(v);
  endtask

  task automatic cmp1(input string nm, input int idx, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @vec %0d: got %b expected %b", nm, idx, act, req);
    end
  endtask

  // Drive one cycle, queue its expectation, then pop and compare at the falling edge.
  task automatic apply(input vec_t v, input int idx, input logic which);
    exp_t e, p;
    rst = v.rst; req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1;
    if (v.chk) begin
      e.idx = idx; e.which = which; e.g0 = v.g0; e.g1 = v.g1;
      e.sel = v.g1; e.valid = v.g0 | v.g1; e.addr = v.g1 ? v.a1 : v.a0;
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      p = sb.pop_front();
      if (!p.which) begin
        cmp1("gnt0", p.idx, gnt0, p.g0);
        cmp1("gnt1", p.idx, gnt1, p.g1);
        cmp1("sel", p.idx, sel, p.sel);
        cmp1("port_valid", p.idx, port_valid, p.valid);
        checks++;
        if (port_addr !== p.addr) begin
          errors++;
          $display("FAIL port_addr @vec %0d: got %h expected %h", p.idx, port_addr, p.addr);
        end
      end else begin
        cmp1("h1_gnt0", p.idx, h_gnt0, p.g0);
        cmp1("h1_gnt1", p.idx, h_gnt1, p.g1);
        checks++;
        if (h_port_addr !== p.addr) begin
          errors++;
          $display("FAIL h1_port_addr @vec %0d: got %h expected %h", p.idx, h_port_addr, p.addr);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

    // T1: reset held two cycles with both requesting; requester 0 wins after release
    add(1, 1, 1, 4'h3, 4'hA, 0, 0, 0);
    add(1, 1, 1, 4'h3, 4'hA, 0, 0, 1);
    add(0, 1, 1, 4'h3, 4'hA, 0, 0, 1);
    add(0, 0, 0, 4'h3, 4'hA, 1, 0, 1);
    // T2: lone requester 1 for three cycles
    add(0, 0, 1, 4'h3, 4'hA, 0, 0, 1);
    add(0, 0, 1, 4'h3, 4'hA, 0, 1, 1);
    add(0, 0, 1, 4'h3, 4'hA, 0, 1, 1);
    add(0, 0, 0, 4'h3, 4'hA, 0, 1, 1);
    add(0, 0, 0, 4'h3, 4'hA, 0, 0, 1);
    // T3: tie after a G1 grant -> G0 first, forced swaps every 4 cycles
    add(0, 1, 1, 4'h3, 4'hA, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 4'h3, 4'hA, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 4'h3, 4'hA, 0, 1, 1);
    add(0, 1, 0, 4'h3, 4'hA, 1, 0, 1);
    // T4: lone owner keeps the port past saturation; addr0 changes pass straight through
    for (int i = 0; i < 10; i++) add(0, 1, 0, 4'(i), 4'hA, 1, 0, 1);
    add(0, 1, 1, 4'h7, 4'hA, 1, 0, 1);
    add(0, 0, 0, 4'h7, 4'hA, 0, 1, 1);
    // T5: early release from G0 hands over with no bubble
    add(0, 1, 0, 4'h5, 4'hC, 0, 0, 1);
    add(0, 1, 1, 4'h5, 4'hC, 1, 0, 1);
    add(0, 0, 1, 4'h5, 4'hC, 1, 0, 1);
    add(0, 1, 1, 4'h5, 4'hC, 0, 1, 1);
    // T6: reset pulse mid-G1 with both requesting
    add(1, 1, 1, 4'h5, 4'hC, 0, 1, 1);
    add(0, 1, 1, 4'h5, 4'hC, 0, 0, 1);
    add(0, 0, 0, 4'h5, 4'hC, 1, 0, 1);
    add(0, 0, 0, 4'h5, 4'hC, 0, 0, 1);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i, 1'b0);

    // MAX_HOLD=1: both requesting alternates every cycle, starting with G0 after reset
    v.rst = 1; v.r0 = 1; v.r1 = 1; v.a0 = 4'h2; v.a1 = 4'hE; v.g0 = 0; v.g1 = 0; v.chk = 0;
    apply(v, 100, 1'b1);
    v.rst = 0; v.chk = 1;
    apply(v, 101, 1'b1);
    for (int i = 0; i < 6; i++) begin
      v.g0 = (i % 2 == 0);
      v.g1 = (i % 2 == 1);
      apply(v, 102 + i, 1'b1);
    end
    // Dropping both requests returns to IDLE one cycle later
    v.r0 = 0; v.r1 = 0; v.g0 = 1; v.g1 = 0;
    apply(v, 108, 1'b1);
    v.g0 = 0;
    apply(v, 109, 1'b1);

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
